// File: rtl/mod_counter_if.sv
// Control/status bundle for mod_counter: count/load controls in, count and flags out.
interface mod_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             CEP;
  logic             CET;
  logic             PE;
  logic             UD;
  logic [WIDTH-1:0] D;
  logic             WCLR;
  logic [WIDTH-1:0] Q;
  logic             TC;
  logic             WRAP;

  modport master (output CEP, CET, PE, UD, D, WCLR, input  Q, TC, WRAP);
  modport slave  (input  CEP, CET, PE, UD, D, WCLR, output Q, TC, WRAP);
endinterface

// File: rtl/mod_counter.sv
// Parametrised up/down modulo counter with 161-style CEP/CET/PE/TC cascade and sticky WRAP.
// Define CNT_SATURATE_EN to saturate at the terminal values instead of wrapping.
module mod_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 16
) (
  input  logic          Clk,
  input  logic          MR,
  mod_counter_if.slave  bus
);
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_r, q_nxt;
  logic             wrap_r, wrap_nxt;
  logic             terminal;
  logic             count_en;
  logic             term_evt;

  assign terminal = bus.UD ? (q_r == TOP) : (q_r == '0);
  assign count_en = bus.PE & bus.CEP & bus.CET;
  assign term_evt = count_en & terminal;

  always_comb begin
    q_nxt    = q_r;
    wrap_nxt = wrap_r;
    if (!bus.PE) begin
      q_nxt = (bus.D > TOP) ? TOP : bus.D;
    end else if (count_en) begin
      if (terminal) begin
`ifdef CNT_SATURATE_EN
        q_nxt = q_r;
`else
        q_nxt = bus.UD ? '0 : TOP;
`endif
      end else begin
        q_nxt = bus.UD ? q_r + 1'b1 : q_r - 1'b1;
      end
    end
    // A terminal event in the same cycle beats WCLR.
    if (term_evt)
      wrap_nxt = 1'b1;
    else if (bus.WCLR)
      wrap_nxt = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (MR) begin
      q_r    <= '0;
      wrap_r <= 1'b0;
    end else begin
      q_r    <= q_nxt;
      wrap_r <= wrap_nxt;
    end
  end

  assign bus.Q    = q_r;
  assign bus.WRAP = wrap_r;
  assign bus.TC   = bus.CET & terminal;
endmodule
